// File: rtl/mem_arb_pkg.sv
// Shared types for the memory/writeback arbiter family: sequencer states and requester identity.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VPU = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational grant between CPU and VPU, round-robin or fixed CPU priority.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int CPU_PRIO = 0
) (
  input  logic   cpu_req,
  input  logic   vpu_req,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t grant
);

  always_comb begin
    grant_valid = cpu_req | vpu_req;
    grant       = OWN_CPU;
    if (cpu_req && vpu_req) begin
      // On a tie the CPU yields only in round-robin mode after it was served last.
      if (CPU_PRIO == 0 && last_owner == OWN_CPU) grant = OWN_VPU;
    end else if (vpu_req) begin
      grant = OWN_VPU;
    end
  end

endmodule

// File: rtl/mem_wb_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage and the VPU,
// one access at a time, with fixed read latency and CPU stall generation.
//
//  state | meaning
//  IDLE  | no access in flight; arbitrate and latch the winner's request
//  ISSUE | memory strobe for exactly one cycle
//  WAIT  | counting down the remaining read latency
//  DONE  | done pulse to the owner; read data returned and captured
module mem_wb_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int CPU_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vpu_req,
  input  logic              vpu_we,
  input  logic [ADDR_W-1:0] vpu_addr,
  input  logic [DATA_W-1:0] vpu_wdata,
  output logic              vpu_done,
  output logic [DATA_W-1:0] vpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter only ever holds RD_LAT-1 down to 1.
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  owner_t            owner;
  owner_t            last_owner;
  owner_t            grant;
  logic              grant_valid;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] vpu_rdata_q;
  logic              done_now;
  logic              rd_done;

  rr_arb2 #(
    .CPU_PRIO(CPU_PRIO)
  ) u_rr_arb2 (
    .cpu_req    (cpu_req),
    .vpu_req    (vpu_req),
    .last_owner (last_owner),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_CPU;
      last_owner  <= OWN_VPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      cpu_rdata_q <= '0;
      vpu_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner <= grant;
            if (grant == OWN_CPU) begin
              we_q    <= cpu_we;
              addr_q  <= cpu_addr;
              wdata_q <= cpu_wdata;
            end else begin
              we_q    <= vpu_we;
              addr_q  <= vpu_addr;
              wdata_q <= vpu_wdata;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q || RD_LAT == 1) begin
            state <= DONE;
          end else begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_ONE) state <= DONE;
          else                cnt   <= cnt - CNT_ONE;
        end
        DONE: begin
          if (!we_q) begin
            if (owner == OWN_CPU) cpu_rdata_q <= mem_rdata;
            else                  vpu_rdata_q <= mem_rdata;
          end
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done_now  = (state == DONE);
  assign rd_done   = done_now && !we_q;

  assign cpu_done  = done_now && (owner == OWN_CPU);
  assign vpu_done  = done_now && (owner == OWN_VPU);
  assign cpu_stall = cpu_req && !cpu_done;

  // Read data bypasses straight from memory in the completion cycle.
  assign cpu_rdata = (rd_done && owner == OWN_CPU) ? mem_rdata : cpu_rdata_q;
  assign vpu_rdata = (rd_done && owner == OWN_VPU) ? mem_rdata : vpu_rdata_q;

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_wb_arbiter.sv
// Self-checking bench: round-robin and CPU-priority instances on shared stimulus,
// directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_wb_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, vpu_req, vpu_we;
  logic [15:0] cpu_addr, vpu_addr;
  logic [31:0] cpu_wdata, vpu_wdata;

  logic        cpu_stall_a, cpu_done_a, vpu_done_a, mem_en_a, mem_we_a;
  logic [31:0] cpu_rdata_a, vpu_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [15:0] mem_addr_a;
  logic        cpu_stall_p, cpu_done_p, vpu_done_p, mem_en_p, mem_we_p;
  logic [31:0] cpu_rdata_p, vpu_rdata_p, mem_wdata_p, mem_rdata_p;
  logic [15:0] mem_addr_p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_wb_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(RD_LAT), .CPU_PRIO(0)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall_a), .cpu_done(cpu_done_a), .cpu_rdata(cpu_rdata_a),
    .vpu_req(vpu_req), .vpu_we(vpu_we), .vpu_addr(vpu_addr), .vpu_wdata(vpu_wdata),
    .vpu_done(vpu_done_a), .vpu_rdata(vpu_rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a)
  );

  mem_wb_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(RD_LAT), .CPU_PRIO(1)) dut_p (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall_p), .cpu_done(cpu_done_p), .cpu_rdata(cpu_rdata_p),
    .vpu_req(vpu_req), .vpu_we(vpu_we), .vpu_addr(vpu_addr), .vpu_wdata(vpu_wdata),
    .vpu_done(vpu_done_p), .vpu_rdata(vpu_rdata_p),
    .mem_en(mem_en_p), .mem_we(mem_we_p), .mem_addr(mem_addr_p), .mem_wdata(mem_wdata_p),
    .mem_rdata(mem_rdata_p)
  );

  function automatic logic [31:0] init_word(logic [7:0] i);
    if (i == 8'h20) return 32'hCAFEF00D;
    return {8'hA5, i, ~i, 8'h3C};
  endfunction

  // Memory models: written words override the initial pattern; reads return RD_LAT cycles later.
  logic [31:0] mem_a [256];
  bit          wr_a  [256];
  logic [31:0] mem_p [256];
  bit          wr_p  [256];
  logic [31:0] pa0, pa1, pp0, pp1;

  always @(posedge clk) begin
    if (mem_en_a && mem_we_a) begin
      mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
      wr_a[mem_addr_a[7:0]]  <= 1'b1;
    end
    pa0 <= !mem_en_a ? 32'hBAD0BAD0 :
           (wr_a[mem_addr_a[7:0]] ? mem_a[mem_addr_a[7:0]] : init_word(mem_addr_a[7:0]));
    pa1 <= pa0;
    if (mem_en_p && mem_we_p) begin
      mem_p[mem_addr_p[7:0]] <= mem_wdata_p;
      wr_p[mem_addr_p[7:0]]  <= 1'b1;
    end
    pp0 <= !mem_en_p ? 32'hBAD0BAD0 :
           (wr_p[mem_addr_p[7:0]] ? mem_p[mem_addr_p[7:0]] : init_word(mem_addr_p[7:0]));
    pp1 <= pp0;
  end
  assign mem_rdata_a = pa1;
  assign mem_rdata_p = pp1;

  // Reference memory contents for the round-robin instance.
  logic [31:0] exp_val     [256];
  bit          exp_written [256];

  function automatic logic [31:0] exp_read(logic [15:0] a);
    return exp_written[a[7:0]] ? exp_val[a[7:0]] : init_word(a[7:0]);
  endfunction

  task automatic exp_write(logic [15:0] a, logic [31:0] d);
    exp_val[a[7:0]]     = d;
    exp_written[a[7:0]] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vpu_req = 0; vpu_we = 0; vpu_addr = '0; vpu_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    cpu_req = 1; cpu_addr = 16'h0011; vpu_addr = 16'h0022;
    rst = 1;
    step();
    checks++;
    if ({mem_en_a, mem_we_a, cpu_done_a, vpu_done_a} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: en/we/cdone/vdone=%b required 0000",
                         {mem_en_a, mem_we_a, cpu_done_a, vpu_done_a});
    end
    checks++;
    if (mem_addr_a !== 16'h0 || mem_wdata_a !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus: addr=%h wdata=%h required 0/0", mem_addr_a, mem_wdata_a);
    end
    checks++;
    if (cpu_rdata_a !== 32'h0 || vpu_rdata_a !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: cpu=%h vpu=%h required 0/0", cpu_rdata_a, vpu_rdata_a);
    end
    checks++;
    if (cpu_stall_a !== 1'b1) begin
      errors++; $display("FAIL reset_stall: got %b required 1", cpu_stall_a);
    end
    step();
    rst = 0;
    vpu_req = 1;
    step();
    checks++;
    if (mem_en_a !== 1'b1 || mem_addr_a !== 16'h0011) begin
      errors++; $display("FAIL reset_first_grant: en=%b addr=%h required 1/0011", mem_en_a, mem_addr_a);
    end
    do_reset();
  endtask

  task automatic test_write();
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF;
    step();
    checks++;
    if ({mem_en_a, mem_we_a} !== 2'b11 || mem_addr_a !== 16'h0010 || mem_wdata_a !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_issue: en=%b we=%b addr=%h wdata=%h required 1/1/0010/deadbeef",
                         mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a);
    end
    step();
    checks++;
    if (cpu_done_a !== 1'b1 || cpu_stall_a !== 1'b0 || vpu_done_a !== 1'b0) begin
      errors++; $display("FAIL write_done: cdone=%b stall=%b vdone=%b required 1/0/0",
                         cpu_done_a, cpu_stall_a, vpu_done_a);
    end
    exp_write(16'h0010, 32'hDEADBEEF);
    cpu_req = 0;
    step();
    checks++;
    if (mem_en_a !== 1'b0 || cpu_done_a !== 1'b0) begin
      errors++; $display("FAIL write_after: en=%b cdone=%b required 0/0", mem_en_a, cpu_done_a);
    end
    cpu_req = 1; cpu_we = 0;
    step(); step(); step();
    checks++;
    if (cpu_done_a !== 1'b1 || cpu_rdata_a !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_readback: cdone=%b rdata=%h required 1/deadbeef", cpu_done_a, cpu_rdata_a);
    end
    idle_inputs();
  endtask

  task automatic test_read();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    step();
    checks++;
    if ({mem_en_a, mem_we_a} !== 2'b10 || mem_addr_a !== 16'h0020) begin
      errors++; $display("FAIL read_issue: en=%b we=%b addr=%h required 1/0/0020", mem_en_a, mem_we_a, mem_addr_a);
    end
    step();
    checks++;
    if (cpu_done_a !== 1'b0 || cpu_stall_a !== 1'b1) begin
      errors++; $display("FAIL read_wait: cdone=%b stall=%b required 0/1", cpu_done_a, cpu_stall_a);
    end
    step();
    checks++;
    if (cpu_done_a !== 1'b1 || cpu_rdata_a !== 32'hCAFEF00D || vpu_done_a !== 1'b0) begin
      errors++; $display("FAIL read_done: cdone=%b rdata=%h vdone=%b required 1/cafef00d/0",
                         cpu_done_a, cpu_rdata_a, vpu_done_a);
    end
    cpu_req = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (cpu_done_a !== 1'b0 || vpu_done_a !== 1'b0 || cpu_rdata_a !== 32'hCAFEF00D) begin
        errors++; $display("FAIL read_hold: cdone=%b vdone=%b rdata=%h required 0/0/cafef00d",
                           cpu_done_a, vpu_done_a, cpu_rdata_a);
      end
    end
  endtask

  task automatic test_round_robin();
    logic ec, ev;
    do_reset();
    cpu_req = 1; cpu_addr = 16'h0030;
    vpu_req = 1; vpu_addr = 16'h0040;
    for (int k = 1; k <= 16; k++) begin
      step();
      ec = (k == 3 || k == 11);
      ev = (k == 7 || k == 15);
      checks++;
      if (cpu_done_a !== ec || vpu_done_a !== ev) begin
        errors++; $display("FAIL rr_order: cycle %0d cdone=%b vdone=%b required %b/%b",
                           k, cpu_done_a, vpu_done_a, ec, ev);
      end
      if (ec) begin
        checks++;
        if (cpu_rdata_a !== exp_read(16'h0030)) begin
          errors++; $display("FAIL rr_cpu_data: got %h required %h", cpu_rdata_a, exp_read(16'h0030));
        end
      end
      if (ev) begin
        checks++;
        if (vpu_rdata_a !== exp_read(16'h0040)) begin
          errors++; $display("FAIL rr_vpu_data: got %h required %h", vpu_rdata_a, exp_read(16'h0040));
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_cpu_prio();
    int nc, nv, bad_data;
    do_reset();
    nc = 0; nv = 0; bad_data = 0;
    cpu_req = 1; cpu_addr = 16'h0030;
    vpu_req = 1; vpu_addr = 16'h0040;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (cpu_done_p) begin
        nc++;
        if (cpu_rdata_p !== init_word(8'h30)) bad_data++;
      end
      if (vpu_done_p) nv++;
    end
    checks++;
    if (nc != 10) begin
      errors++; $display("FAIL prio_cpu_count: got %0d required 10", nc);
    end
    checks++;
    if (nv != 0) begin
      errors++; $display("FAIL prio_vpu_starved: vpu_done pulses %0d required 0", nv);
    end
    checks++;
    if (bad_data != 0) begin
      errors++; $display("FAIL prio_data: %0d wrong read words required 0", bad_data);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    vpu_req = 1; vpu_we = 0; vpu_addr = 16'h0044;
    step();
    checks++;
    if (mem_en_a !== 1'b1 || mem_addr_a !== 16'h0044) begin
      errors++; $display("FAIL abort_issue: en=%b addr=%h required 1/0044", mem_en_a, mem_addr_a);
    end
    step();
    rst = 1; vpu_req = 0;
    step();
    checks++;
    if (mem_en_a !== 1'b0 || vpu_done_a !== 1'b0 || vpu_rdata_a !== 32'h0) begin
      errors++; $display("FAIL abort_reset: en=%b vdone=%b vrdata=%h required 0/0/0",
                         mem_en_a, vpu_done_a, vpu_rdata_a);
    end
    rst = 0;
    cpu_req = 1; cpu_addr = 16'h0050;
    vpu_req = 1; vpu_addr = 16'h0060;
    step();
    checks++;
    if (mem_en_a !== 1'b1 || mem_addr_a !== 16'h0050) begin
      errors++; $display("FAIL abort_regrant: en=%b addr=%h required 1/0050", mem_en_a, mem_addr_a);
    end
    step(); step();
    checks++;
    if (cpu_done_a !== 1'b1 || vpu_done_a !== 1'b0) begin
      errors++; $display("FAIL abort_cpu_done: cdone=%b vdone=%b required 1/0", cpu_done_a, vpu_done_a);
    end
    idle_inputs();
  endtask

  // Transaction-level model: winner by tie rule, completion by op latency,
  // the loser starts in the cycle after the winner's done.
  task automatic test_random();
    bit          last_cpu;
    int          sel, lat_c, lat_v, ec, ev, kmax;
    logic        cw, vw;
    logic [15:0] ca, va;
    logic [31:0] cd, vd;
    do_reset();
    last_cpu = 0;
    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(1, 3);
      cw = 1'($urandom_range(0, 1)); vw = 1'($urandom_range(0, 1));
      ca = 16'($urandom); va = 16'($urandom);
      cd = $urandom; vd = $urandom;
      lat_c = cw ? 2 : 1 + RD_LAT;
      lat_v = vw ? 2 : 1 + RD_LAT;
      ec = -1; ev = -1;
      if (sel == 1) ec = lat_c;
      else if (sel == 2) ev = lat_v;
      else if (last_cpu) begin ev = lat_v; ec = lat_v + 1 + lat_c; end
      else begin ec = lat_c; ev = lat_c + 1 + lat_v; end
      kmax = (ec > ev) ? ec : ev;
      cpu_req = sel[0]; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      vpu_req = sel[1]; vpu_we = vw; vpu_addr = va; vpu_wdata = vd;
      for (int k = 1; k <= kmax; k++) begin
        step();
        checks++;
        if (cpu_done_a !== (k == ec) || vpu_done_a !== (k == ev)) begin
          errors++; $display("FAIL rand_done: round %0d cycle %0d cdone=%b vdone=%b required %b/%b",
                             r, k, cpu_done_a, vpu_done_a, (k == ec), (k == ev));
        end
        if (k == ec) begin
          if (cw) exp_write(ca, cd);
          else begin
            checks++;
            if (cpu_rdata_a !== exp_read(ca)) begin
              errors++; $display("FAIL rand_cpu_data: round %0d addr %h got %h required %h",
                                 r, ca, cpu_rdata_a, exp_read(ca));
            end
          end
          cpu_req = 0;
        end
        if (k == ev) begin
          if (vw) exp_write(va, vd);
          else begin
            checks++;
            if (vpu_rdata_a !== exp_read(va)) begin
              errors++; $display("FAIL rand_vpu_data: round %0d addr %h got %h required %h",
                                 r, va, vpu_rdata_a, exp_read(va));
            end
          end
          vpu_req = 0;
        end
      end
      last_cpu = (ec > ev);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_cpu_prio();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_wb_arbiter.md
Name: mem_wb_arbiter

Overview:
Sequences the single-ported data memory behind the memory/writeback stage and shares it between the CPU MEM stage and the VPU.
- Arbitrates one access at a time, drives the memory port and counts fixed read latency.
- Returns read data to the owning requester.
- Generates the CPU pipeline stall so memory_writeback holds until its access completes.

Parameters:
ADDR_W, 16, address width
DATA_W, 32, data width
RD_LAT, 2, memory read latency in cycles (mem_rdata valid RD_LAT cycles after the mem_en cycle); legal range >=1
CPU_PRIO, 0, 0 = round-robin; 1 = CPU always wins ties (the VPU may starve; this is accepted)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_done
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  cpu_req && !cpu_done (combinational)
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  CPU read data
vpu_req, vpu_we, vpu_addr, vpu_wdata  in  1/1/ADDR_W/DATA_W  same meaning for the VPU
vpu_done  out  1  VPU completion pulse
vpu_rdata  out  DATA_W  VPU read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Registers: owner, last_owner, latched we/addr/wdata, a latency counter, and cpu_rdata_q/vpu_rdata_q.
- IDLE:
  - With any request, pick the owner and latch that requester's we/addr/wdata, then go to ISSUE.
  - CPU_PRIO=0: with both requesting, grant the one that is not last_owner. CPU_PRIO=1: CPU wins.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive mem_en=1, mem_we=latched we; mem_addr/mem_wdata = latched values.
  - A write goes to DONE. A read goes to DONE if RD_LAT=1, otherwise to WAIT with the counter loaded to RD_LAT-1.
- WAIT: decrement the counter; go to DONE when it reaches 1.
- DONE (1 cycle):
  - Pulse the owner's done.
  - For a read, the owner's rdata is driven from mem_rdata this cycle and captured into its rdata_q.
  - Set last_owner=owner and go to IDLE.
- Outside a DONE read, each rdata output holds its rdata_q.
- Latency, with the request seen in IDLE at cycle t:
  - Write: done at t+2.
  - Read: done at t+1+RD_LAT.
  - The cycle after done is always IDLE. A req still high in that cycle is treated as a new request.
- mem_en=0 and mem_we=0 in every state except ISSUE. mem_addr/mem_wdata hold their last latched values.
- Request inputs are ignored outside IDLE. If a requester drops req mid-access, the access still completes and done still pulses.
- Reset (any state, including mid-access):
  - Next cycle: state IDLE, last_owner=VPU (so the CPU wins the first tie).
  - mem_en, mem_we, cpu_done, vpu_done = 0.
  - mem_addr, mem_wdata, rdata_q = 0.
  - An aborted access produces no done pulse.
- A non-owner's done is always 0; both done outputs are never high together.

Decomposition:
- mem_arb_pkg: state_t enum (IDLE/ISSUE/WAIT/DONE) and owner_t enum (OWN_CPU/OWN_VPU).
- Sub-module rr_arb2: 2-way grant from req pair, last_owner and CPU_PRIO. It is combinational and reused by later VPU arbiters.
- The FSM, latency counter and data path stay in mem_wb_arbiter.

Test Plan:
- Reset: rst=1 for 2 cycles with cpu_req=1 -> all outputs 0, cpu_stall=1; after release, CPU is granted first.
- CPU write addr=0x0010, wdata=0xDEADBEEF at cycle t -> at t+1: mem_en=1, mem_we=1, addr 0x0010, wdata 0xDEADBEEF; at t+2: cpu_done=1, cpu_stall=0; at t+3: mem_en=0.
- CPU read addr=0x0020, RD_LAT=2, memory model returns 0xCAFEF00D -> issue at t+1, cpu_done and cpu_rdata=0xCAFEF00D at t+3; cpu_rdata holds 0xCAFEF00D afterwards; vpu_done stays 0.
- CPU and VPU both continuously requesting reads, CPU_PRIO=0 -> grant order CPU, VPU, CPU, VPU with done pulses 4 cycles apart; each rdata matches its own address.
- Same stimulus with CPU_PRIO=1 -> 10 consecutive CPU accesses, vpu_done never asserted.
- rst asserted in WAIT of a VPU read -> next cycle IDLE, mem_en=0, no vpu_done; then simultaneous requests -> CPU granted first.
